// File: rtl/inst_encoder_if.sv
// inst_encoder_if: field-record input, encoded-word output and status bundle for inst_encoder.
interface inst_encoder_if #(parameter int DEPTH = 4);
    localparam int LW = $clog2(DEPTH) + 1;
    logic          in_valid;
    logic          in_ready;
    logic          in_fmt;
    logic [3:0]    in_op;
    logic [2:0]    in_rd;
    logic [2:0]    in_rs;
    logic [2:0]    in_rt;
    logic [15:0]   in_imm;
    logic [15:0]   out_inst;
    logic          out_valid;
    logic          out_ready;
    logic          flush;
    logic          err;
    logic [7:0]    err_cnt;
    logic [LW-1:0] level;
    modport master (
        output in_valid, in_fmt, in_op, in_rd, in_rs, in_rt, in_imm, out_ready, flush,
        input  in_ready, out_inst, out_valid, err, err_cnt, level
    );
    modport slave (
        input  in_valid, in_fmt, in_op, in_rd, in_rs, in_rt, in_imm, out_ready, flush,
        output in_ready, out_inst, out_valid, err, err_cnt, level
    );
endinterface

// File: rtl/inst_encoder.sv
// inst_encoder: encodes register/immediate field records into 16-bit words, queued in a DEPTH-entry FIFO.
module inst_encoder #(
    parameter int DEPTH = 4
) (
    input logic         clk,
    input logic         res,
    inst_encoder_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [15:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wptr, r_rptr;
    logic [LW-1:0] r_level;
    logic          r_alive;
    logic          r_err;
    logic [7:0]    r_err_cnt;

    logic          w_ready, w_accept, w_legal, w_push, w_pop, w_empty;
    logic [15:0]   w_word;

    always_comb begin
        w_empty  = (r_level == '0);
        w_ready  = r_alive && (r_level < LW'(DEPTH)) && !bus.flush;
        w_accept = bus.in_valid && w_ready;
        w_legal  = !bus.in_fmt || (bus.in_imm[15:8] == {8{bus.in_imm[8]}});
        w_push   = w_accept && w_legal;
        w_pop    = !w_empty && bus.out_ready && !bus.flush;
        w_word   = bus.in_fmt ? {bus.in_op, bus.in_rd, bus.in_imm[8:0]}
                              : {bus.in_op, bus.in_rd, bus.in_rs, bus.in_rt, 3'b000};
    end

    // Storage has no reset: emptiness is tracked by r_level and the head is masked when empty.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= w_word;
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_level   <= '0;
            r_alive   <= 1'b0;
            r_err     <= 1'b0;
            r_err_cnt <= '0;
        end else begin
            r_alive   <= 1'b1;
            r_err     <= w_accept && !w_legal;
            r_err_cnt <= r_err_cnt + {7'd0, (w_accept && !w_legal && r_err_cnt != 8'hFF)};
            if (bus.flush) begin
                r_wptr  <= '0;
                r_rptr  <= '0;
                r_level <= '0;
            end else begin
                r_wptr  <= w_push ? r_wptr + AW'(1) : r_wptr;
                r_rptr  <= w_pop ? r_rptr + AW'(1) : r_rptr;
                r_level <= (w_push && !w_pop) ? r_level + LW'(1) :
                           (!w_push && w_pop) ? r_level - LW'(1) : r_level;
            end
        end
    end

    assign bus.in_ready  = w_ready;
    assign bus.out_valid = !w_empty;
    assign bus.out_inst  = w_empty ? 16'h0000 : r_mem[r_rptr];
    assign bus.err       = r_err;
    assign bus.err_cnt   = r_err_cnt;
    assign bus.level     = r_level;
endmodule

// File: tb/tb_inst_encoder.sv
// tb_inst_encoder: directed scenario tasks with hand-computed expectations for inst_encoder.
module tb_inst_encoder;
    logic clk = 1'b0;
    logic res = 1'b0;
    int checks = 0;
    int errors = 0;

    inst_encoder_if #(.DEPTH(4)) bus();
    inst_encoder #(.DEPTH(4)) dut (.clk(clk), .res(res), .bus(bus));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rec(input logic fmt, input logic [3:0] op, input logic [2:0] rd,
                           input logic [2:0] rs, input logic [2:0] rt, input logic [15:0] imm);
        bus.in_fmt = fmt;
        bus.in_op  = op;
        bus.in_rd  = rd;
        bus.in_rs  = rs;
        bus.in_rt  = rt;
        bus.in_imm = imm;
    endtask

    function automatic logic [15:0] enc_reg(input logic [2:0] rd, input logic [2:0] rs, input logic [2:0] rt);
        return {4'h3, rd, rs, rt, 3'b000};
    endfunction

    task automatic test_reset();
        #2;
        checks++; if (bus.level !== 3'd0) begin errors++; $display("FAIL reset_level got %0d want 0", bus.level); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
        checks++; if (bus.out_inst !== 16'h0000) begin errors++; $display("FAIL reset_out_inst got %h want 0000", bus.out_inst); end
        checks++; if (bus.err_cnt !== 8'd0) begin errors++; $display("FAIL reset_err_cnt got %0d want 0", bus.err_cnt); end
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b want 0", bus.in_ready); end
        tick();
        res = 1'b1;
        #1;
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL release_in_ready_early got %b want 0", bus.in_ready); end
        tick();
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready got %b want 1", bus.in_ready); end
    endtask

    task automatic test_reg_format();
        set_rec(1'b0, 4'h1, 3'd3, 3'd5, 3'd6, 16'h0000);
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        checks++; if (bus.out_inst !== 16'h1770) begin errors++; $display("FAIL reg_out_inst got %h want 1770", bus.out_inst); end
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL reg_out_valid got %b want 1", bus.out_valid); end
        checks++; if (bus.level !== 3'd1) begin errors++; $display("FAIL reg_level got %0d want 1", bus.level); end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        checks++; if (bus.level !== 3'd0) begin errors++; $display("FAIL reg_pop_level got %0d want 0", bus.level); end
        checks++; if (bus.out_inst !== 16'h0000) begin errors++; $display("FAIL reg_empty_inst got %h want 0000", bus.out_inst); end
    endtask

    task automatic test_imm_bounds();
        bus.in_valid = 1'b1;
        set_rec(1'b1, 4'h9, 3'd2, 3'd0, 3'd0, 16'hFF00);
        tick();
        set_rec(1'b1, 4'h9, 3'd2, 3'd0, 3'd0, 16'h00FF);
        tick();
        checks++; if (bus.level !== 3'd2) begin errors++; $display("FAIL imm_level got %0d want 2", bus.level); end
        checks++; if (bus.out_inst !== 16'h9500) begin errors++; $display("FAIL imm_neg_inst got %h want 9500", bus.out_inst); end
        set_rec(1'b1, 4'h9, 3'd2, 3'd0, 3'd0, 16'h0100);
        tick();
        bus.in_valid = 1'b0;
        checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL imm_err got %b want 1", bus.err); end
        checks++; if (bus.err_cnt !== 8'd1) begin errors++; $display("FAIL imm_err_cnt got %0d want 1", bus.err_cnt); end
        checks++; if (bus.level !== 3'd2) begin errors++; $display("FAIL imm_illegal_level got %0d want 2", bus.level); end
        bus.out_ready = 1'b1;
        checks++; if (bus.out_inst !== 16'h9500) begin errors++; $display("FAIL imm_head0 got %h want 9500", bus.out_inst); end
        tick();
        checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL imm_err_clear got %b want 0", bus.err); end
        checks++; if (bus.out_inst !== 16'h94FF) begin errors++; $display("FAIL imm_head1 got %h want 94FF", bus.out_inst); end
        tick();
        bus.out_ready = 1'b0;
        checks++; if (bus.level !== 3'd0) begin errors++; $display("FAIL imm_drain_level got %0d want 0", bus.level); end
    endtask

    task automatic test_full_backpressure();
        logic [15:0] exp_full [5] = '{16'hA000, 16'hA201, 16'hA402, 16'hA603, 16'hA804};
        int k = 0;
        logic acc_now;
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            set_rec(1'b1, 4'hA, 3'(i), 3'd0, 3'd0, 16'(i));
            if (i < 4) tick();
        end
        checks++; if (bus.level !== 3'd4) begin errors++; $display("FAIL full_level got %0d want 4", bus.level); end
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready got %b want 0", bus.in_ready); end
        tick();
        tick();
        checks++; if (bus.level !== 3'd4) begin errors++; $display("FAIL full_hold_level got %0d want 4", bus.level); end
        checks++; if (bus.out_inst !== 16'hA000) begin errors++; $display("FAIL full_hold_inst got %h want A000", bus.out_inst); end
        bus.out_ready = 1'b1;
        for (int c = 0; c < 20 && k < 5; c++) begin
            acc_now = bus.in_valid && bus.in_ready;
            if (bus.out_valid) begin
                checks++; if (bus.out_inst !== exp_full[k]) begin errors++; $display("FAIL full_order[%0d] got %h want %h", k, bus.out_inst, exp_full[k]); end
                k++;
            end
            tick();
            if (acc_now) bus.in_valid = 1'b0;
        end
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b0;
        checks++; if (k !== 5) begin errors++; $display("FAIL full_pop_count got %0d want 5", k); end
        checks++; if (bus.level !== 3'd0) begin errors++; $display("FAIL full_drain_level got %0d want 0", bus.level); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] q[$];
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1;
        for (int j = 0; j < 2; j++) begin
            set_rec(1'b0, 4'h3, 3'(j), ~3'(j), 3'(j) + 3'd1, 16'h0000);
            q.push_back(enc_reg(3'(j), ~3'(j), 3'(j) + 3'd1));
            tick();
        end
        bus.out_ready = 1'b1;
        for (int j = 2; j < 12; j++) begin
            set_rec(1'b0, 4'h3, 3'(j), ~3'(j), 3'(j) + 3'd1, 16'h0000);
            checks++; if (bus.level !== 3'd2) begin errors++; $display("FAIL b2b_level[%0d] got %0d want 2", j, bus.level); end
            checks++; if (bus.out_inst !== q[0]) begin errors++; $display("FAIL b2b_inst[%0d] got %h want %h", j, bus.out_inst, q[0]); end
            tick();
            void'(q.pop_front());
            q.push_back(enc_reg(3'(j), ~3'(j), 3'(j) + 3'd1));
        end
        bus.in_valid = 1'b0;
        for (int j = 0; j < 2; j++) begin
            checks++; if (bus.out_inst !== q[0]) begin errors++; $display("FAIL b2b_drain[%0d] got %h want %h", j, bus.out_inst, q[0]); end
            tick();
            void'(q.pop_front());
        end
        bus.out_ready = 1'b0;
        checks++; if (bus.level !== 3'd0) begin errors++; $display("FAIL b2b_end_level got %0d want 0", bus.level); end
    endtask

    task automatic test_flush();
        bus.in_valid = 1'b1;
        for (int j = 0; j < 3; j++) begin
            set_rec(1'b0, 4'h5, 3'(j), 3'd1, 3'd2, 16'h0000);
            tick();
        end
        checks++; if (bus.level !== 3'd3) begin errors++; $display("FAIL flush_pre_level got %0d want 3", bus.level); end
        set_rec(1'b1, 4'h5, 3'd0, 3'd0, 3'd0, 16'h0200);
        bus.flush = 1'b1;
        bus.out_ready = 1'b1;
        #1;
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready got %b want 0", bus.in_ready); end
        tick();
        bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        checks++; if (bus.level !== 3'd0) begin errors++; $display("FAIL flush_level got %0d want 0", bus.level); end
        checks++; if (bus.out_inst !== 16'h0000) begin errors++; $display("FAIL flush_inst got %h want 0000", bus.out_inst); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid got %b want 0", bus.out_valid); end
        checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL flush_err got %b want 0", bus.err); end
        checks++; if (bus.err_cnt !== 8'd1) begin errors++; $display("FAIL flush_err_cnt got %0d want 1", bus.err_cnt); end
    endtask

    task automatic test_saturation();
        int exp_cnt = 1;
        set_rec(1'b1, 4'h7, 3'd1, 3'd0, 3'd0, 16'h0100);
        bus.in_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            tick();
            exp_cnt = (exp_cnt < 255) ? exp_cnt + 1 : 255;
            checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL sat_err[%0d] got %b want 1", i, bus.err); end
            checks++; if (bus.err_cnt !== 8'(exp_cnt)) begin errors++; $display("FAIL sat_cnt[%0d] got %0d want %0d", i, bus.err_cnt, exp_cnt); end
        end
        bus.in_valid = 1'b0;
        checks++; if (bus.level !== 3'd0) begin errors++; $display("FAIL sat_level got %0d want 0", bus.level); end
        tick();
        checks++; if (bus.err_cnt !== 8'd255) begin errors++; $display("FAIL sat_final got %0d want 255", bus.err_cnt); end
    endtask

    task automatic test_reset_midstream();
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b0;
        for (int j = 0; j < 2; j++) begin
            set_rec(1'b0, 4'h6, 3'(j), 3'd2, 3'd3, 16'h0000);
            tick();
        end
        set_rec(1'b1, 4'h6, 3'd0, 3'd0, 3'd0, 16'h0400);
        tick();
        #2;
        res = 1'b0;
        #1;
        checks++; if (bus.level !== 3'd0) begin errors++; $display("FAIL mid_level got %0d want 0", bus.level); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL mid_out_valid got %b want 0", bus.out_valid); end
        checks++; if (bus.out_inst !== 16'h0000) begin errors++; $display("FAIL mid_out_inst got %h want 0000", bus.out_inst); end
        checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL mid_err got %b want 0", bus.err); end
        checks++; if (bus.err_cnt !== 8'd0) begin errors++; $display("FAIL mid_err_cnt got %0d want 0", bus.err_cnt); end
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL mid_in_ready got %b want 0", bus.in_ready); end
        bus.in_valid = 1'b0;
        tick();
        res = 1'b1;
        tick();
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL mid_release_ready got %b want 1", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL mid_release_valid got %b want 0", bus.out_valid); end
        checks++; if (bus.out_inst !== 16'h0000) begin errors++; $display("FAIL mid_release_inst got %h want 0000", bus.out_inst); end
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.flush = 1'b0;
        set_rec(1'b0, 4'h0, 3'd0, 3'd0, 3'd0, 16'h0000);
        test_reset();
        test_reg_format();
        test_imm_bounds();
        test_full_backpressure();
        test_back_to_back();
        test_flush();
        test_saturation();
        test_reset_midstream();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/inst_encoder.md
INST_ENCODER -- requirements
Module: inst_encoder

Interface
REQ-001 The block SHALL have the parameter DEPTH, default 4, giving the number of output FIFO entries (power of two, minimum 2).
REQ-002 The block SHALL have the port clk, input, 1 bit: the single clock, rising-edge active.
REQ-003 The block SHALL have the port res, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have the port in_valid, input, 1 bit: the field record is valid.
REQ-005 The block SHALL have the port in_ready, output, 1 bit: the block can accept a record.
REQ-006 The block SHALL have the port in_fmt, input, 1 bit: 0 = register format, 1 = immediate format.
REQ-007 The block SHALL have the port in_op, input, 4 bits: opcode.
REQ-008 The block SHALL have the ports in_rd, in_rs and in_rt, inputs, 3 bits each: register selects.
REQ-009 The block SHALL have the port in_imm, input, 16 bits: signed (two's complement) immediate.
REQ-010 The block SHALL have the port out_inst, output, 16 bits: encoded instruction word at the FIFO head.
REQ-011 The block SHALL have the port out_valid, output, 1 bit: out_inst holds a word.
REQ-012 The block SHALL have the port out_ready, input, 1 bit: the consumer takes the word.
REQ-013 The block SHALL have the port flush, input, 1 bit: synchronous FIFO clear.
REQ-014 The block SHALL have the port err, output, 1 bit: one-cycle pulse when a record is rejected.
REQ-015 The block SHALL have the port err_cnt, output, 8 bits: saturating count of rejected records.
REQ-016 The block SHALL have the port level, output, log2(DEPTH)+1 bits: FIFO occupancy.

Function
REQ-017 A record SHALL be accepted on a rising clk edge where in_valid=1 and in_ready=1, and in_ready SHALL equal (level < DEPTH) && !flush.
REQ-018 Register format SHALL encode as {in_op, in_rd, in_rs, in_rt, 3'b000}, i.e. op[15:12], rd[11:9], rs[8:6], rt[5:3], with zeros in [2:0].
REQ-019 Immediate format SHALL encode as {in_op, in_rd, in_imm[8:0]}, so that sign-extending bits [8:0] by 7 copies of bit 8 reproduces in_imm.
REQ-020 An immediate-format record SHALL be legal only if in_imm lies in -256..255, i.e. in_imm[15:8] are all equal to in_imm[8].
REQ-021 An illegal record SHALL be accepted, consuming the handshake, but SHALL NOT be written to the FIFO.
REQ-022 On an illegal record, err SHALL be 1 in the cycle after acceptance, and err_cnt SHALL increment by 1, saturating at 255.
REQ-023 A legal accepted record SHALL be written into the FIFO tail, and the earliest it appears on out_inst (with out_valid=1) SHALL be the next cycle; latency is 1 cycle with no bypass.
REQ-024 The output SHALL pop on a rising edge where out_valid=1 and out_ready=1.
REQ-025 While out_valid=1 and out_ready=0, out_inst SHALL be held stable.
REQ-026 When the FIFO is empty, out_valid SHALL be 0 and out_inst SHALL be 16'h0000 (the NOP encoding).
REQ-027 A simultaneous push and pop SHALL leave level unchanged; this SHALL be permitted at any level below DEPTH, and when level = DEPTH only a pop occurs.
REQ-028 Read and write pointers SHALL wrap modulo DEPTH.
REQ-029 level SHALL equal the number of stored words and SHALL never exceed DEPTH.
REQ-030 When flush=1 at a rising edge, the block SHALL empty the FIFO (level=0, pointers=0), no push or pop SHALL occur, err SHALL be 0 the next cycle, and err_cnt SHALL be retained.
REQ-031 The block SHALL store words in order; the output sequence SHALL equal the sequence of legal accepted records.

Reset
REQ-032 While res=0, asynchronously: level=0, pointers=0, out_valid=0, out_inst=16'h0000, err=0, err_cnt=0.
REQ-033 While res=0, in_ready SHALL be 0, and in_ready SHALL become 1 on the first rising edge after res deasserts.
REQ-034 Reset asserted mid-stream SHALL discard all stored words, and no partial word SHALL appear after release.

Verification
REQ-035 The bench SHALL cover register format: fmt=0, op=4'h1, rd=3, rs=5, rt=6 -> next cycle out_inst=16'h1770, out_valid=1.
REQ-036 The bench SHALL cover immediate boundaries: fmt=1, op=4'h9, rd=2, imm=-256 -> 16'h9500; then imm=255 -> 16'h94FF; then imm=256 -> not stored, err pulse, err_cnt=1.
REQ-037 The bench SHALL cover full and backpressure: DEPTH=4, out_ready=0, push 5 records -> level=4, in_ready=0 after the 4th, and the 5th is held until out_ready=1; the output order is preserved.
REQ-038 The bench SHALL cover simultaneous push and pop at level=2 -> level stays 2, and pointers wrap correctly across 10 such cycles.
REQ-039 The bench SHALL cover saturation: 300 illegal records -> err_cnt=255, an err pulse each time, and level=0.
REQ-040 The bench SHALL cover flush and reset: flush with level=3 -> level=0, out_inst=16'h0000, err_cnt retained; res low mid-burst -> all outputs at reset values immediately, without waiting for clk.
